// File: rtl/vector_lane_alu_if.sv
// Operand/result bundle between the controller, the vector register file and vector_lane_alu.
// The slave side is the ALU; the master side is whoever issues operations.
interface vector_lane_alu_if #(
  parameter int BITS = 8,
  parameter int N    = 64
);
  logic                   start;
  logic [2:0]             op_sel;
  logic                   scalar_sel;
  logic                   sat;
  logic [N-1:0][BITS-1:0] A;
  logic [N-1:0][BITS-1:0] B;
  logic [BITS-1:0]        A_len;
  logic [BITS-1:0]        B_len;
  logic [BITS-1:0]        scalar;
  logic                   busy;
  logic                   done;
  logic [N-1:0][BITS-1:0] S;
  logic [BITS-1:0]        S_len;

  modport master (
    output start, op_sel, scalar_sel, sat, A, B, A_len, B_len, scalar,
    input  busy, done, S, S_len
  );

  modport slave (
    input  start, op_sel, scalar_sel, sat, A, B, A_len, B_len, scalar,
    output busy, done, S, S_len
  );
endinterface

// File: rtl/vector_lane_alu.sv
// Length-aware vector ALU: LANES element ALUs sweep the result vector one beat per cycle,
// with optional signed saturation, signed compare and zero-fill beyond the result length.
module vector_lane_alu #(
  parameter int BITS       = 8,
  parameter int N          = 64,
  parameter int LANES      = 8,
  parameter int MULT_SHIFT = 0
) (
  input  logic             clk,
  input  logic             set,
  vector_lane_alu_if.slave bus
);
  localparam int BEATS = N / LANES;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  localparam logic signed [BITS-1:0]   SMAX = {1'b0, {(BITS-1){1'b1}}};
  localparam logic signed [BITS-1:0]   SMIN = {1'b1, {(BITS-1){1'b0}}};
  localparam logic signed [2*BITS-1:0] PMAX = {{(BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic signed [2*BITS-1:0] PMIN = {{(BITS+1){1'b1}}, {(BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [2:0]             op_q, op_d;
  logic                   scalar_sel_q, scalar_sel_d;
  logic                   sat_q, sat_d;
  logic [BITS-1:0]        scalar_q, scalar_d;
  logic [N-1:0][BITS-1:0] s_q, s_d;
  logic [BITS-1:0]        s_len_q, s_len_d;

  logic [BITS-1:0]        max_len;
  logic [BITS-1:0]        acc_len;
  logic                   last_beat;
  logic [BITS-1:0]        lane_res [LANES];
  logic [EW-1:0]          lane_idx [LANES];
  logic [LANES-1:0]       lane_wr;

  // Result length for an accepted operation, clamped to the vector capacity.
  always_comb begin
    max_len = bus.A_len;
    if (!bus.scalar_sel && (bus.B_len > bus.A_len)) begin
      max_len = bus.B_len;
    end
    acc_len = (32'(max_len) > 32'(N)) ? BITS'(N) : max_len;
  end

  assign last_beat = ((32'(k_q) + 32'd1) * 32'(LANES)) >= 32'(s_len_q);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [31:0]              e_full;
    logic signed [BITS-1:0]   a_el;
    logic signed [BITS-1:0]   b_el;
    logic signed [BITS:0]     sum;
    logic signed [BITS:0]     dif;
    logic signed [2*BITS-1:0] prod;
    logic signed [2*BITS-1:0] prod_sh;
    logic signed [BITS-1:0]   res;

    assign e_full        = 32'(k_q) * 32'(LANES) + 32'(gi);
    assign lane_idx[gi]  = e_full[EW-1:0];
    assign lane_wr[gi]   = e_full < 32'(s_len_q);
    assign a_el          = bus.A[lane_idx[gi]];
    assign b_el          = scalar_sel_q ? scalar_q : bus.B[lane_idx[gi]];

    // One guard bit is enough to see add/sub overflow: the top two bits disagree.
    assign sum     = {a_el[BITS-1], a_el} + {b_el[BITS-1], b_el};
    assign dif     = {a_el[BITS-1], a_el} - {b_el[BITS-1], b_el};
    assign prod    = a_el * b_el;
    assign prod_sh = prod >>> MULT_SHIFT;

    always_comb begin
      res = '0;
      case (op_q)
        OP_ADD: begin
          res = sum[BITS-1:0];
          if (sat_q && (sum[BITS] != sum[BITS-1])) res = sum[BITS] ? SMIN : SMAX;
        end
        OP_SUB: begin
          res = dif[BITS-1:0];
          if (sat_q && (dif[BITS] != dif[BITS-1])) res = dif[BITS] ? SMIN : SMAX;
        end
        OP_MUL: begin
          res = prod_sh[BITS-1:0];
          if (sat_q && (prod_sh > PMAX)) res = SMAX;
          if (sat_q && (prod_sh < PMIN)) res = SMIN;
        end
        OP_CMP: begin
          if (a_el > b_el)       res = BITS'(1);
          else if (a_el == b_el) res = '0;
          else                   res = '1;
        end
        OP_AND:  res = a_el & b_el;
        OP_OR:   res = a_el | b_el;
        OP_XOR:  res = a_el ^ b_el;
        default: res = ~a_el;
      endcase
    end

    assign lane_res[gi] = res;
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    op_d         = op_q;
    scalar_sel_d = scalar_sel_q;
    sat_d        = sat_q;
    scalar_d     = scalar_q;
    s_d          = s_q;
    s_len_d      = s_len_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d         = bus.op_sel;
          scalar_sel_d = bus.scalar_sel;
          sat_d        = bus.sat;
          scalar_d     = bus.scalar;
          s_len_d      = acc_len;
          s_d          = '0;
          k_d          = '0;
          state_d      = (acc_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // Elements at or beyond the result length keep the zero written at acceptance.
        for (int j = 0; j < LANES; j++) begin
          if (lane_wr[j]) s_d[lane_idx[j]] = lane_res[j];
        end
        if (last_beat) state_d = DONE;
        else           k_d     = k_q + KW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (set) begin
      state_q      <= IDLE;
      k_q          <= '0;
      op_q         <= '0;
      scalar_sel_q <= 1'b0;
      sat_q        <= 1'b0;
      scalar_q     <= '0;
      s_q          <= '0;
      s_len_q      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      op_q         <= op_d;
      scalar_sel_q <= scalar_sel_d;
      sat_q        <= sat_d;
      scalar_q     <= scalar_d;
      s_q          <= s_d;
      s_len_q      <= s_len_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.S     = s_q;
  assign bus.S_len = s_len_q;
endmodule

// File: tb/tb_vector_lane_alu.sv
// Scoreboard bench for vector_lane_alu: expected vectors are queued at issue time
// from an integer reference model and compared when the done pulse arrives.
module tb_vector_lane_alu;
  localparam int BITS       = 8;
  localparam int N          = 64;
  localparam int LANES      = 8;
  localparam int MULT_SHIFT = 0;

  typedef logic [N-1:0][BITS-1:0] vec_t;
  typedef struct {
    vec_t            s;
    logic [BITS-1:0] len;
    int              done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic set;
  vector_lane_alu_if #(.BITS(BITS), .N(N)) bus ();

  vector_lane_alu #(
    .BITS(BITS), .N(N), .LANES(LANES), .MULT_SHIFT(MULT_SHIFT)
  ) dut (
    .clk(clk),
    .set(set),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  vec_t a_v, b_v;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [BITS-1:0] ref_elem(input logic [2:0] op, input logic sat_i,
                                               input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    int sa, sb, r;
    int hi = (1 << (BITS-1)) - 1;
    int lo = -(1 << (BITS-1));
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = 0;
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: r = (sa * sb) >>> MULT_SHIFT;
      3'd3: return (sa > sb) ? BITS'(1) : ((sa == sb) ? '0 : '1);
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return ~a;
    endcase
    if (sat_i) begin
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
    end
    return BITS'(r);
  endfunction

  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic issue(input logic [2:0] op, input logic ssel, input logic sat_i,
                       input int alen, input int blen, input logic [BITS-1:0] scal);
    exp_t e;
    int   l;
    bus.op_sel     = op;
    bus.scalar_sel = ssel;
    bus.sat        = sat_i;
    bus.A          = a_v;
    bus.B          = b_v;
    bus.A_len      = BITS'(alen);
    bus.B_len      = BITS'(blen);
    bus.scalar     = scal;
    l = ssel ? alen : ((alen > blen) ? alen : blen);
    if (l > N) l = N;
    e.s = '0;
    for (int i = 0; i < l; i++) e.s[i] = ref_elem(op, sat_i, a_v[i], ssel ? scal : b_v[i]);
    e.len      = BITS'(l);
    e.done_cyc = (l == 0) ? 1 : (l + LANES - 1) / LANES + 1;
    sb_q.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done, checks timing, busy, length and vector; ends one cycle after done.
  task automatic collect(input string name);
    exp_t            e;
    int              dc;
    logic            busy_ok;
    logic [BITS-1:0] len_c1;
    e       = sb_q.pop_front();
    dc      = 0;
    busy_ok = 1'b1;
    len_c1  = bus.S_len;
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        dc = c;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (dc !== e.done_cyc) begin
      n_err++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, dc, e.done_cyc);
    end
    n_vec++;
    if (busy_ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_window: got busy low before done, want busy high cycles 1..%0d", name, e.done_cyc);
    end
    n_vec++;
    if (len_c1 !== e.len || bus.S_len !== e.len) begin
      n_err++;
      $display("FAIL %s S_len: got %0d (cycle1 %0d) want %0d", name, bus.S_len, len_c1, e.len);
    end
    n_vec++;
    if (bus.S !== e.s) begin
      n_err++;
      $display("FAIL %s S: got %h want %h", name, bus.S, e.s);
    end
    @(negedge clk);
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, bus.done, bus.busy);
    end
    $display("%s: L=%0d done@%0d", name, e.len, dc);
  endtask

  task automatic check_elem(input string name, input int idx, input logic [BITS-1:0] want);
    n_vec++;
    if (bus.S[idx] !== want) begin
      n_err++;
      $display("FAIL %s S[%0d]: got %h want %h", name, idx, bus.S[idx], want);
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.S !== '0 || bus.S_len !== '0) begin
      n_err++;
      $display("FAIL %s reset_state: got busy=%b done=%b S_len=%0d S=%h want all 0",
               name, bus.busy, bus.done, bus.S_len, bus.S);
    end
    $display("%s: checked idle/zero state", name);
  endtask

  task automatic test_reset();
    set = 1'b1;
    repeat (3) @(negedge clk);
    set = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
  endtask

  task automatic test_vector_add();
    for (int i = 0; i < N; i++) begin
      a_v[i] = BITS'(i);
      b_v[i] = BITS'(2 * i);
    end
    issue(3'b000, 1'b0, 1'b0, 10, 20, '0);
    collect("vector_add");
    check_elem("vector_add", 19, 8'd57);
    check_elem("vector_add", 20, 8'd0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < N; i++) begin
      a_v[i] = 8'd100;
      b_v[i] = BITS'($urandom);
    end
    issue(3'b000, 1'b1, 1'b0, 8, 30, 8'd100);
    collect("add_wrap");
    check_elem("add_wrap", 0, 8'hC8);
    issue(3'b000, 1'b1, 1'b1, 8, 30, 8'd100);
    collect("add_sat");
    check_elem("add_sat", 7, 8'h7F);
    for (int i = 0; i < N; i++) a_v[i] = 8'h9C;
    issue(3'b001, 1'b1, 1'b1, 8, 0, 8'd100);
    collect("sub_sat");
    check_elem("sub_sat", 3, 8'h80);
  endtask

  task automatic test_multiply();
    for (int i = 0; i < N; i++) begin
      a_v[i] = 8'hFD;
      b_v[i] = 8'h05;
    end
    issue(3'b010, 1'b0, 1'b0, 8, 8, '0);
    collect("mul_neg");
    check_elem("mul_neg", 0, 8'hF1);
    for (int i = 0; i < N; i++) begin
      a_v[i] = 8'd20;
      b_v[i] = 8'd20;
    end
    issue(3'b010, 1'b0, 1'b0, 8, 8, '0);
    collect("mul_wrap");
    check_elem("mul_wrap", 5, 8'h90);
    issue(3'b010, 1'b0, 1'b1, 8, 8, '0);
    collect("mul_sat");
    check_elem("mul_sat", 5, 8'h7F);
  endtask

  task automatic test_compare();
    a_v = '0;
    b_v = '0;
    a_v[0] = 8'h7F; b_v[0] = 8'h80;
    a_v[1] = 8'h80; b_v[1] = 8'h01;
    a_v[2] = 8'h33; b_v[2] = 8'h33;
    issue(3'b011, 1'b0, 1'b1, 3, 3, '0);
    collect("cmp_signed");
    check_elem("cmp_signed", 0, 8'h01);
    check_elem("cmp_signed", 1, 8'hFF);
    check_elem("cmp_signed", 2, 8'h00);
  endtask

  task automatic test_all_ops();
    for (int op = 0; op < 8; op++) begin
      for (int i = 0; i < N; i++) begin
        a_v[i] = BITS'($urandom);
        b_v[i] = BITS'($urandom);
      end
      issue(3'(op), 1'($urandom), 1'($urandom), 1 + int'($urandom_range(0, 63)),
            int'($urandom_range(0, 63)), BITS'($urandom));
      collect($sformatf("random_op%0d", op));
    end
  endtask

  task automatic test_length_edges();
    issue(3'b110, 1'b0, 1'b0, 0, 0, '0);
    collect("len_zero");
    for (int i = 0; i < N; i++) begin
      a_v[i] = BITS'($urandom);
      b_v[i] = BITS'($urandom);
    end
    issue(3'b101, 1'b0, 1'b0, 200, 5, '0);
    collect("len_clamp");
    issue(3'b000, 1'b0, 1'b0, 9, 3, '0);
    collect("len_nine");
    for (int i = 9; i < 16; i++) check_elem("len_nine", i, 8'h00);
  endtask

  task automatic test_start_during_run();
    exp_t e;
    int   ndone, dc;
    for (int i = 0; i < N; i++) begin
      a_v[i] = BITS'($urandom);
      b_v[i] = BITS'($urandom);
    end
    issue(3'b000, 1'b0, 1'b0, 24, 24, '0);
    e     = sb_q.pop_front();
    ndone = 0;
    dc    = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        bus.start  = 1'b1;
        bus.op_sel = 3'b110;
      end
      if (c == 3) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (dc == 0) dc = c;
      end
      @(negedge clk);
    end
    n_vec++;
    if (ndone !== 1 || dc !== e.done_cyc) begin
      n_err++;
      $display("FAIL start_in_run done_pulses: got %0d at cycle %0d want 1 at cycle %0d", ndone, dc, e.done_cyc);
    end
    n_vec++;
    if (bus.S !== e.s) begin
      n_err++;
      $display("FAIL start_in_run S: got %h want %h", bus.S, e.s);
    end
    $display("start_in_run: %0d done pulse(s)", ndone);
  endtask

  task automatic test_reset_mid_op();
    int ndone;
    issue(3'b000, 1'b0, 1'b0, 24, 24, '0);
    void'(sb_q.pop_front());
    @(negedge clk);
    set = 1'b1;
    @(negedge clk);
    set = 1'b0;
    check_idle_zero("reset_mid_op");
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clk);
    end
    n_vec++;
    if (ndone !== 0) begin
      n_err++;
      $display("FAIL reset_mid_op done_after_reset: got %0d pulses want 0", ndone);
    end
  endtask

  task automatic test_set_and_start();
    int bad;
    bus.op_sel     = 3'b000;
    bus.scalar_sel = 1'b0;
    bus.A_len      = 8'd8;
    bus.B_len      = 8'd8;
    set            = 1'b1;
    bus.start      = 1'b1;
    @(negedge clk);
    set       = 1'b0;
    bus.start = 1'b0;
    bad       = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.S_len !== '0) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL set_and_start stays_idle: got %0d non-idle cycles want 0", bad);
    end
    $display("set_and_start: %0d non-idle cycles", bad);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) begin
        a_v[i] = BITS'($urandom);
        b_v[i] = BITS'($urandom);
      end
      issue(3'($urandom), 1'b0, 1'($urandom), int'($urandom_range(0, 80)),
            int'($urandom_range(0, 80)), BITS'($urandom));
      collect($sformatf("back_to_back%0d", t));
    end
  endtask

  initial begin
    set            = 1'b1;
    bus.start      = 1'b0;
    bus.op_sel     = '0;
    bus.scalar_sel = 1'b0;
    bus.sat        = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    bus.A_len      = '0;
    bus.B_len      = '0;
    bus.scalar     = '0;
    a_v            = '0;
    b_v            = '0;
    @(negedge clk);
    test_reset();
    test_vector_add();
    test_saturation();
    test_multiply();
    test_compare();
    test_all_ops();
    test_length_edges();
    test_start_during_run();
    test_reset_mid_op();
    test_set_and_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
